// File: rtl/interp_pkg.sv
// rtl/interp_pkg.sv - shared state encoding, defaults and MV field layout for interp_ctrl
package interp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_HPASS,
        ST_VPASS,
        ST_DONE
    } state_t;

    localparam int BLK_SIZE_DEF = 8;
    localparam int TAPS_DEF     = 8;

    // Each MV component is signed quarter-pel: upper two bits integer, lower two phase.
    localparam int MV_FIELD_W    = 2;
    localparam int MV_INT_X_LSB  = 6;
    localparam int MV_FRAC_X_LSB = 4;
    localparam int MV_INT_Y_LSB  = 2;
    localparam int MV_FRAC_Y_LSB = 0;

endpackage

// File: rtl/interp_ctrl_if.sv
// rtl/interp_ctrl_if.sv - control/status bundle between a requester and interp_ctrl
interface interp_ctrl_if;

    logic               START;
    logic signed [7:0]  MV_IN;
    logic               MEM_STALL;
    logic               BUSY;
    logic               RD_EN;
    logic signed [5:0]  ROW_ADDR;
    logic signed [1:0]  INT_X;
    logic signed [1:0]  INT_Y;
    logic        [1:0]  FILT_SEL_H;
    logic        [1:0]  FILT_SEL_V;
    logic               H_EN;
    logic               V_EN;
    logic               DONE;

    modport master (
        output START, MV_IN, MEM_STALL,
        input  BUSY, RD_EN, ROW_ADDR, INT_X, INT_Y, FILT_SEL_H, FILT_SEL_V, H_EN, V_EN, DONE
    );

    modport slave (
        input  START, MV_IN, MEM_STALL,
        output BUSY, RD_EN, ROW_ADDR, INT_X, INT_Y, FILT_SEL_H, FILT_SEL_V, H_EN, V_EN, DONE
    );

endinterface

// File: rtl/mv_decode.sv
// rtl/mv_decode.sv - splits a packed quarter-pel MV into integer parts and filter phases
module mv_decode
    import interp_pkg::*;
(
    input  logic        [7:0] mv,
    output logic signed [1:0] int_x,
    output logic        [1:0] filt_sel_h,
    output logic signed [1:0] int_y,
    output logic        [1:0] filt_sel_v
);

    // Two's-complement top bits of a quarter-pel value already give the floor.
    assign int_x      = mv[MV_INT_X_LSB  +: MV_FIELD_W];
    assign filt_sel_h = mv[MV_FRAC_X_LSB +: MV_FIELD_W];
    assign int_y      = mv[MV_INT_Y_LSB  +: MV_FIELD_W];
    assign filt_sel_v = mv[MV_FRAC_Y_LSB +: MV_FIELD_W];

endmodule

// File: rtl/interp_ctrl.sv
// rtl/interp_ctrl.sv - sequences horizontal row reads and vertical filter passes for one block
module interp_ctrl
    import interp_pkg::*;
#(
    parameter int BLK_SIZE = BLK_SIZE_DEF,
    parameter int TAPS     = TAPS_DEF
) (
    input  logic          CLK,
    input  logic          RST_ASYNC_N,
    interp_ctrl_if.slave  bus
);

    localparam int ROWS_MAX = BLK_SIZE + TAPS - 1;
    localparam int CNT_W    = $clog2(ROWS_MAX + 1);

    state_t             state, state_nxt;
    logic        [7:0]  mv_q;
    logic [CNT_W-1:0]   row_cnt;
    logic [CNT_W-1:0]   col_cnt;
    logic [CNT_W-1:0]   rows_h;
    logic signed [5:0]  base;

    logic signed [1:0]  int_x, int_y;
    logic        [1:0]  filt_sel_h, filt_sel_v;
    logic signed [5:0]  int_y_ext;
    logic               v_filt;
    logic               row_last, col_last;

    logic               busy, rd_en, h_en, v_en, done;
    logic signed [5:0]  row_addr;

    mv_decode u_mv_decode (
        .mv         (mv_q),
        .int_x      (int_x),
        .filt_sel_h (filt_sel_h),
        .int_y      (int_y),
        .filt_sel_v (filt_sel_v)
    );

    assign int_y_ext = {{4{int_y[1]}}, int_y};
    assign v_filt    = (filt_sel_v != 2'd0);
    assign row_last  = (row_cnt == rows_h - CNT_W'(1));
    assign col_last  = (col_cnt == CNT_W'(BLK_SIZE - 1));

    always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
        if (!RST_ASYNC_N) begin
            state   <= ST_IDLE;
            mv_q    <= '0;
            row_cnt <= '0;
            col_cnt <= '0;
            rows_h  <= '0;
            base    <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (bus.START) mv_q <= bus.MV_IN;
                end
                ST_LOAD: begin
                    // Vertical filtering needs TAPS/2-1 extra rows above and TAPS/2 below.
                    rows_h  <= v_filt ? CNT_W'(ROWS_MAX) : CNT_W'(BLK_SIZE);
                    base    <= v_filt ? int_y_ext - 6'(TAPS / 2 - 1) : int_y_ext;
                    row_cnt <= '0;
                    col_cnt <= '0;
                end
                ST_HPASS: begin
                    if (!bus.MEM_STALL && !row_last) row_cnt <= row_cnt + CNT_W'(1);
                end
                ST_VPASS: begin
                    if (!bus.MEM_STALL && !col_last) col_cnt <= col_cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != ST_IDLE);
        rd_en     = 1'b0;
        h_en      = 1'b0;
        v_en      = 1'b0;
        done      = 1'b0;
        row_addr  = '0;
        case (state)
            ST_IDLE: begin
                if (bus.START) state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                state_nxt = ST_HPASS;
            end
            ST_HPASS: begin
                row_addr = base + 6'(row_cnt);
                if (!bus.MEM_STALL) begin
                    rd_en = 1'b1;
                    h_en  = (filt_sel_h != 2'd0);
                    if (row_last) state_nxt = v_filt ? ST_VPASS : ST_DONE;
                end
            end
            ST_VPASS: begin
                if (!bus.MEM_STALL) begin
                    v_en = 1'b1;
                    if (col_last) state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign bus.BUSY       = busy;
    assign bus.RD_EN      = rd_en;
    assign bus.ROW_ADDR   = row_addr;
    assign bus.H_EN       = h_en;
    assign bus.V_EN       = v_en;
    assign bus.DONE       = done;
    assign bus.INT_X      = int_x;
    assign bus.INT_Y      = int_y;
    assign bus.FILT_SEL_H = filt_sel_h;
    assign bus.FILT_SEL_V = filt_sel_v;

endmodule

// File: tb/tb_interp_ctrl.sv
// tb/tb_interp_ctrl.sv - scoreboard bench for interp_ctrl with directed MV vectors
module tb_interp_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    interp_ctrl_if bus ();

    interp_ctrl #(.BLK_SIZE(8), .TAPS(8)) dut (
        .CLK         (clk),
        .RST_ASYNC_N (rst_n),
        .bus         (bus)
    );

    typedef struct {
        int kind;   // 0 row read, 1 vertical column, 2 done
        int cyc;
        int addr;
        int h;
    } ev_t;

    typedef struct {
        logic [7:0] mv;
        int rows, base, h, v, done;
        int st_lo, st_hi, st_addr, ign, rst;
        int ix, fh, iy, fv;
    } vec_t;

    ev_t  q[$];
    vec_t tbl[7];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   t0 = 0;
    bit   active = 1'b0;
    bit   done_seen = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_ev(input int kind, input int c, input int a, input int h);
        ev_t e;
        e.kind = kind; e.cyc = c; e.addr = a; e.h = h;
        q.push_back(e);
    endtask

    always @(negedge clk) begin : monitor
        int k, kind, n;
        ev_t e;
        if (active && rst_n) begin
            k    = cyc - t0 + 1;
            n    = int'(bus.RD_EN) + int'(bus.V_EN) + int'(bus.DONE);
            kind = (n > 1) ? 9 : bus.RD_EN ? 0 : bus.V_EN ? 1 : bus.DONE ? 2 : -1;
            if (bus.DONE) done_seen = 1'b1;
            if (kind >= 0) begin
                if (q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_output: kind %0d at cycle %0d, expected none", kind, k);
                end else begin
                    e = q.pop_front();
                    chk("ev_kind", kind, e.kind);
                    chk("ev_cycle", k, e.cyc);
                    if (kind == 0) begin
                        chk("row_addr", bus.ROW_ADDR, e.addr);
                        chk("h_en", bus.H_EN, e.h);
                    end
                end
            end
        end
    end

    task automatic run(input vec_t t);
        int c, k;
        c = 2;
        for (int r = 0; r < t.rows; r++) begin
            while (c >= t.st_lo && c <= t.st_hi) c++;
            push_ev(0, c, t.base + r, t.h);
            c++;
        end
        if (t.v != 0) begin
            for (int i = 0; i < 8; i++) begin
                while (c >= t.st_lo && c <= t.st_hi) c++;
                push_ev(1, c, 0, 0);
                c++;
            end
        end
        push_ev(2, t.done, 0, 0);
        done_seen = 1'b0;

        @(posedge clk); #1;
        bus.START = 1'b1;
        bus.MV_IN = t.mv;
        @(posedge clk); #1;
        t0 = cyc;
        active = 1'b1;
        bus.START = 1'b0;
        bus.MV_IN = ~t.mv;
        k = 1;
        while (1) begin
            bus.MEM_STALL = (k >= t.st_lo && k <= t.st_hi);
            bus.START     = (k == t.ign);
            if (k == t.rst) begin
                #2;
                rst_n = 1'b0;
                #1;
                chk("rst_busy", bus.BUSY, 0);
                chk("rst_rd_en", bus.RD_EN, 0);
                chk("rst_done", bus.DONE, 0);
                chk("rst_row_addr", bus.ROW_ADDR, 0);
                q.delete();
                active = 1'b0;
                @(negedge clk); #1;
                rst_n = 1'b1;
                bus.MEM_STALL = 1'b0;
                return;
            end
            @(negedge clk); #1;
            if (k >= t.st_lo && k <= t.st_hi) begin
                chk("stall_rd_en", bus.RD_EN, 0);
                chk("stall_row_addr", bus.ROW_ADDR, t.st_addr);
            end
            if (done_seen) break;
            if (k > 60) begin
                vectors++;
                miscompares++;
                $display("FAIL timeout: no DONE by cycle %0d, expected cycle %0d", k, t.done);
                break;
            end
            @(posedge clk); #1;
            k++;
        end
        bus.START = 1'b0;
        bus.MEM_STALL = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        active = 1'b0;
        chk("queue_drain", q.size(), 0);
        chk("int_x", bus.INT_X, t.ix);
        chk("filt_sel_h", bus.FILT_SEL_H, t.fh);
        chk("int_y", bus.INT_Y, t.iy);
        chk("filt_sel_v", bus.FILT_SEL_V, t.fv);
        chk("idle_busy", bus.BUSY, 0);
        q.delete();
    endtask

    initial begin
        //          mv     rows base h v done lo  hi addr ign rst  ix fh iy fv
        tbl[0] = '{8'h00,  8,   0, 0, 0, 10, -1, -2, 0, -1, -1,  0, 0, 0, 0};
        tbl[1] = '{8'h11, 15,  -3, 1, 1, 25, -1, -2, 0, -1, -1,  0, 1, 0, 1};
        tbl[2] = '{8'hF0,  8,   0, 1, 0, 10, -1, -2, 0, -1, -1, -1, 3, 0, 0};
        tbl[3] = '{8'h00,  8,   0, 0, 0, 12,  4,  5, 2, -1, -1,  0, 0, 0, 0};
        tbl[4] = '{8'h00,  8,   0, 0, 0, 10, -1, -2, 0,  5, -1,  0, 0, 0, 0};
        tbl[5] = '{8'h00,  8,   0, 0, 0, 10, -1, -2, 0, -1,  6,  0, 0, 0, 0};
        tbl[6] = '{8'h9E, 15,  -4, 1, 1, 25, -1, -2, 0, -1, -1, -2, 1, -1, 2};

        bus.START = 1'b0;
        bus.MV_IN = 8'h00;
        bus.MEM_STALL = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", bus.BUSY, 0);
        chk("reset_rd_en", bus.RD_EN, 0);
        chk("reset_done", bus.DONE, 0);
        chk("reset_row_addr", bus.ROW_ADDR, 0);
        chk("reset_h_en", bus.H_EN, 0);
        chk("reset_v_en", bus.V_EN, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) run(tbl[i]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/interp_ctrl.md
INTERP_CTRL -- requirements
Module: interp_ctrl

Interface
REQ-001 Parameter BLK_SIZE, default 8, output block width/height in pixels (rows per pass).
REQ-002 Parameter TAPS, default 8, interpolation filter taps (even, >=2).
REQ-003 CLK  in  1  single clock, all state on rising edge.
REQ-004 RST_ASYNC_N  in  1  asynchronous, active-low reset.
REQ-005 START  in  1  request, sampled only in IDLE.
REQ-006 MV_IN  in  8 signed  motion vector; [7:4] horizontal, [3:0] vertical, each signed quarter-pel.
REQ-007 MEM_STALL  in  1  reference memory not ready; freezes pass progress.
REQ-008 BUSY  out  1  high in every non-IDLE state.
REQ-009 RD_EN  out  1  reference row read request.
REQ-010 ROW_ADDR  out  6 signed  reference row offset for current read.
REQ-011 INT_X, INT_Y  out  2 signed each  integer MV parts of latched MV.
REQ-012 FILT_SEL_H, FILT_SEL_V  out  2 each  fractional phases (0..3) of latched MV.
REQ-013 H_EN, V_EN  out  1 each  horizontal/vertical filter active.
REQ-014 DONE  out  1  one-cycle completion pulse.

Function
REQ-015 MV decode: INT_X = MV_IN[7:6], FILT_SEL_H = MV_IN[5:4], INT_Y = MV_IN[3:2], FILT_SEL_V = MV_IN[1:0] (arithmetic floor for negatives).
REQ-016 States SHALL be IDLE, LOAD, HPASS, VPASS, DONE.
REQ-017 IDLE: START=1 latches MV_IN on that edge and moves to LOAD; START in any other state SHALL be ignored.
REQ-018 LOAD lasts exactly one cycle, computes rows_h and base, then moves to HPASS.
REQ-019 rows_h = BLK_SIZE+TAPS-1 if FILT_SEL_V!=0, else BLK_SIZE.
REQ-020 base = INT_Y-(TAPS/2-1) if FILT_SEL_V!=0, else INT_Y; sign-extended to 6 bits.
REQ-021 HPASS: RD_EN=1, ROW_ADDR=base+row_cnt, row_cnt 0..rows_h-1, one row per non-stalled cycle.
REQ-022 H_EN = 1 in HPASS only when FILT_SEL_H!=0 (else bypass/copy).
REQ-023 After last HPASS row: to VPASS if FILT_SEL_V!=0, else to DONE.
REQ-024 VPASS: V_EN=1, RD_EN=0, col_cnt 0..BLK_SIZE-1, one per non-stalled cycle, then DONE.
REQ-025 MEM_STALL=1 in HPASS/VPASS: counters and state hold; RD_EN, H_EN and V_EN forced 0 that cycle; ROW_ADDR holds.
REQ-026 DONE state asserts DONE=1 for exactly one cycle, then IDLE; MEM_STALL ignored in LOAD/DONE.
REQ-027 INT_*/FILT_SEL_* SHALL hold latched values from LOAD until next accepted START.
REQ-028 Latency, no stall: DONE asserted 2+rows_h (+BLK_SIZE if FILT_SEL_V!=0) cycles after the START edge.

Reset
REQ-029 RST_ASYNC_N low SHALL immediately force IDLE, counters 0, all outputs 0, at any time including mid-pass.
REQ-030 After reset release, first START is accepted at the first rising edge with START=1.

Structure
REQ-031 Package interp_pkg SHALL hold state encoding, BLK_SIZE/TAPS defaults and MV field bit positions.
REQ-032 Combinational MV split SHALL be sub-module mv_decode; FSM and counters remain in interp_ctrl.

Verification (defaults BLK_SIZE=8, TAPS=8; START edge = cycle 0)
REQ-033 MV_IN=8'h00 -> HPASS cycles 2..9, ROW_ADDR 0..7, H_EN=0, no VPASS, DONE cycle 10.
REQ-034 MV_IN=8'h11 -> ROW_ADDR -3..11 over cycles 2..16 with H_EN=1, V_EN cycles 17..24, DONE cycle 25.
REQ-035 MV_IN=8'hF0 -> INT_X=-1, FILT_SEL_H=3, INT_Y=0, FILT_SEL_V=0, 8 rows, DONE cycle 10.
REQ-036 MV_IN=8'h00, MEM_STALL=1 in cycles 4-5 -> ROW_ADDR holds 2 with RD_EN=0, DONE cycle 12.
REQ-037 START pulsed at cycle 5 during run -> ignored, single DONE at cycle 10.
REQ-038 Reset asserted cycle 6 mid-HPASS -> BUSY/RD_EN/DONE 0 immediately; next START runs normally.
